// File: rtl/dpram_be_clr.sv
// dpram_be_clr: single-clock true dual-port RAM with per-byte write enables
// on both ports and a hardware clear sequencer that zeroes the array after
// reset or on an i_clr request.
//
// Collision policy: on a same-address double write, port 1 wins each byte
// both ports enable; port 2 bytes apply where only port 2 enables them.
//
// Build option DPRAM_BE_CLR_RDW_FWD_EN:
//   defined   - a read colliding with the other port's write returns the
//               post-write word (write-first forwarding)
//   undefined - such a read returns the pre-write word (read-first)
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_CLEAR | counter walks 0..DEPTH-1 zeroing one word per cycle; ports
//          | ignored, read data held at 0, i_clr ignored
// ST_READY | normal dual-port access; i_clr restarts the sweep

module dpram_be_clr #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    localparam int ADDR_W = $clog2(DEPTH),
    localparam int BE_W   = DATA_W / 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clr,
    output logic              o_ready,

    input  logic              i_p1_en,
    input  logic              i_p1_we,
    input  logic [BE_W-1:0]   i_p1_be,
    input  logic [ADDR_W-1:0] i_p1_addr,
    input  logic [DATA_W-1:0] i_p1_wd,
    output logic [DATA_W-1:0] o_p1_rd,

    input  logic              i_p2_en,
    input  logic              i_p2_we,
    input  logic [BE_W-1:0]   i_p2_be,
    input  logic [ADDR_W-1:0] i_p2_addr,
    input  logic [DATA_W-1:0] i_p2_wd,
    output logic [DATA_W-1:0] o_p2_rd
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // One extra bit so DEPTH itself is representable for the range compare.
    localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W-1:0] clr_cnt;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              acc_ok;
    logic              p1_in_rng;
    logic              p2_in_rng;
    logic              p1_wr;
    logic              p2_wr;
    logic              p1_rd;
    logic              p2_rd;
    logic [DATA_W-1:0] p1_old;
    logic [DATA_W-1:0] p2_old;
    logic [DATA_W-1:0] p1_rd_word;
    logic [DATA_W-1:0] p2_rd_word;

    function automatic logic [DATA_W-1:0] merge_be(
        input logic [DATA_W-1:0] old_w,
        input logic [BE_W-1:0]   be,
        input logic [DATA_W-1:0] wd
    );
        logic [DATA_W-1:0] res;
        res = old_w;
        for (int k = 0; k < BE_W; k++) begin
            if (be[k]) begin
                res[8*k +: 8] = wd[8*k +: 8];
            end
        end
        return res;
    endfunction

    // Access qualification: ports act only in READY and only in range.
    always_comb begin
        acc_ok    = (state == ST_READY);
        p1_in_rng = ({1'b0, i_p1_addr} < DEPTH_L);
        p2_in_rng = ({1'b0, i_p2_addr} < DEPTH_L);
        p1_wr     = acc_ok & i_p1_en &  i_p1_we & p1_in_rng;
        p2_wr     = acc_ok & i_p2_en &  i_p2_we & p2_in_rng;
        p1_rd     = acc_ok & i_p1_en & ~i_p1_we & p1_in_rng;
        p2_rd     = acc_ok & i_p2_en & ~i_p2_we & p2_in_rng;
    end

    // Raw array reads; only used when the matching range check passes.
    always_comb begin
        p1_old = p1_in_rng ? mem[i_p1_addr] : '0;
        p2_old = p2_in_rng ? mem[i_p2_addr] : '0;
    end

    // Read-during-write selection. A reading port never writes in the same
    // cycle, so the post-write word is the old word merged with the other
    // port's enabled bytes only.
    always_comb begin
`ifdef DPRAM_BE_CLR_RDW_FWD_EN
        p1_rd_word = (p2_wr && (i_p2_addr == i_p1_addr))
                     ? merge_be(p1_old, i_p2_be, i_p2_wd) : p1_old;
        p2_rd_word = (p1_wr && (i_p1_addr == i_p2_addr))
                     ? merge_be(p2_old, i_p1_be, i_p1_wd) : p2_old;
`else
        p1_rd_word = p1_old;
        p2_rd_word = p2_old;
`endif
    end

    // Sequencer: clear sweep after reset or i_clr, then normal access.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
            o_ready <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    if (clr_cnt == LAST_ADDR) begin
                        state   <= ST_READY;
                        clr_cnt <= '0;
                        o_ready <= 1'b1;
                    end else begin
                        clr_cnt <= clr_cnt + ADDR_W'(1);
                    end
                end
                ST_READY: begin
                    if (i_clr) begin
                        state   <= ST_CLEAR;
                        clr_cnt <= '0;
                        o_ready <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_CLEAR;
                    clr_cnt <= '0;
                    o_ready <= 1'b0;
                end
            endcase
        end
    end

    // Array writes: clear sweep, else byte writes with port 1 applied last
    // so it wins any byte both ports enable at the same address.
    always_ff @(posedge i_clk) begin
        if (state == ST_CLEAR) begin
            mem[clr_cnt] <= '0;
        end else begin
            for (int k = 0; k < BE_W; k++) begin
                if (p2_wr && i_p2_be[k]) begin
                    mem[i_p2_addr][8*k +: 8] <= i_p2_wd[8*k +: 8];
                end
            end
            for (int k = 0; k < BE_W; k++) begin
                if (p1_wr && i_p1_be[k]) begin
                    mem[i_p1_addr][8*k +: 8] <= i_p1_wd[8*k +: 8];
                end
            end
        end
    end

    // Registered read data; zero on writes, disabled ports, out-of-range
    // addresses and throughout the clear sweep.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_p1_rd <= '0;
            o_p2_rd <= '0;
        end else begin
            o_p1_rd <= p1_rd ? p1_rd_word : '0;
            o_p2_rd <= p2_rd ? p2_rd_word : '0;
        end
    end

endmodule

// File: tb/tb_dpram_be_clr.sv
// Bench for dpram_be_clr: two instances (DEPTH=64 and DEPTH=48) share one
// stimulus stream; each is checked every cycle against its own array model,
// plus directed constant checks for the documented scenarios.

module tb_dpram_be_clr;

`ifdef DPRAM_BE_CLR_RDW_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic        p1_en, p1_we, p2_en, p2_we;
    logic [3:0]  p1_be, p2_be;
    logic [5:0]  p1_addr, p2_addr;
    logic [31:0] p1_wd, p2_wd;

    logic        rdy_a, rdy_b;
    logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // model state, index 0 = DEPTH 64, index 1 = DEPTH 48
    int          m_depth [2] = '{64, 48};
    logic [31:0] m_mem [2][64];
    int          m_clr_left [2];
    logic        m_rdy [2];
    logic [31:0] m_rd1 [2];
    logic [31:0] m_rd2 [2];

    always #5 clk = ~clk;

    dpram_be_clr #(.DATA_W(32), .DEPTH(64)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .o_ready(rdy_a),
        .i_p1_en(p1_en), .i_p1_we(p1_we), .i_p1_be(p1_be), .i_p1_addr(p1_addr),
        .i_p1_wd(p1_wd), .o_p1_rd(rd1_a),
        .i_p2_en(p2_en), .i_p2_we(p2_we), .i_p2_be(p2_be), .i_p2_addr(p2_addr),
        .i_p2_wd(p2_wd), .o_p2_rd(rd2_a)
    );

    dpram_be_clr #(.DATA_W(32), .DEPTH(48)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .o_ready(rdy_b),
        .i_p1_en(p1_en), .i_p1_we(p1_we), .i_p1_be(p1_be), .i_p1_addr(p1_addr),
        .i_p1_wd(p1_wd), .o_p1_rd(rd1_b),
        .i_p2_en(p2_en), .i_p2_we(p2_we), .i_p2_be(p2_be), .i_p2_addr(p2_addr),
        .i_p2_wd(p2_wd), .o_p2_rd(rd2_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_clr_left[d] = m_depth[d];
            m_rdy[d] = 1'b0;
            m_rd1[d] = '0;
            m_rd2[d] = '0;
        end
    endtask

    function automatic logic [31:0] put_bytes(input logic [31:0] w, input logic [3:0] be,
                                              input logic [31:0] wd);
        logic [31:0] r;
        r = w;
        for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = wd[8*k +: 8];
        return r;
    endfunction

    // One clock edge of the behavioural model for instance d.
    task automatic model_step(input int d);
        logic [31:0] nw [64];
        int dep;
        dep = m_depth[d];
        if (m_clr_left[d] > 0) begin
            m_mem[d][dep - m_clr_left[d]] = '0;
            m_clr_left[d]--;
            m_rd1[d] = '0;
            m_rd2[d] = '0;
            m_rdy[d] = (m_clr_left[d] == 0);
        end else begin
            for (int i = 0; i < 64; i++) nw[i] = m_mem[d][i];
            if (p2_en && p2_we && int'(p2_addr) < dep)
                nw[p2_addr] = put_bytes(nw[p2_addr], p2_be, p2_wd);
            if (p1_en && p1_we && int'(p1_addr) < dep)
                nw[p1_addr] = put_bytes(nw[p1_addr], p1_be, p1_wd);
            m_rd1[d] = (p1_en && !p1_we && int'(p1_addr) < dep)
                       ? (FWD ? nw[p1_addr] : m_mem[d][p1_addr]) : '0;
            m_rd2[d] = (p2_en && !p2_we && int'(p2_addr) < dep)
                       ? (FWD ? nw[p2_addr] : m_mem[d][p2_addr]) : '0;
            for (int i = 0; i < 64; i++) m_mem[d][i] = nw[i];
            if (clr) begin
                m_clr_left[d] = dep;
                m_rdy[d] = 1'b0;
            end
        end
    endtask

    task automatic check_all();
        chk("a_ready", {31'd0, rdy_a}, {31'd0, m_rdy[0]});
        chk("a_rd1", rd1_a, m_rd1[0]);
        chk("a_rd2", rd2_a, m_rd2[0]);
        chk("b_ready", {31'd0, rdy_b}, {31'd0, m_rdy[1]});
        chk("b_rd1", rd1_b, m_rd1[1]);
        chk("b_rd2", rd2_b, m_rd2[1]);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        check_all();
    endtask

    task automatic idle();
        clr = 0;
        p1_en = 0; p1_we = 0; p1_be = 0; p1_addr = 0; p1_wd = 0;
        p2_en = 0; p2_we = 0; p2_be = 0; p2_addr = 0; p2_wd = 0;
    endtask

    task automatic set_p1(input logic en, input logic we, input logic [3:0] be,
                          input logic [5:0] addr, input logic [31:0] wd);
        p1_en = en; p1_we = we; p1_be = be; p1_addr = addr; p1_wd = wd;
    endtask

    task automatic set_p2(input logic en, input logic we, input logic [3:0] be,
                          input logic [5:0] addr, input logic [31:0] wd);
        p2_en = en; p2_we = we; p2_be = be; p2_addr = addr; p2_wd = wd;
    endtask

    // Cycles until each instance raises ready; 0 means the bound expired.
    task automatic wait_ready(output int n_a, output int n_b);
        n_a = 0;
        n_b = 0;
        for (int n = 1; n <= 200; n++) begin
            tick();
            if (rdy_b && n_b == 0) n_b = n;
            if (rdy_a) begin
                n_a = n;
                break;
            end
        end
    endtask

    function automatic logic [5:0] rnd_addr();
        if ($urandom_range(0, 3) == 0) return 6'($urandom_range(44, 63));
        return 6'($urandom_range(0, 7));
    endfunction

    initial begin
        int ta, tb;
        logic [31:0] rdw_exp;

        // reset and initial clear
        idle();
        rst_n = 1'b0;
        model_reset();
        #3;
        check_all();
        #9 rst_n = 1'b1;
        wait_ready(ta, tb);
        chk("rise_after_reset_64", 32'(ta), 32'd64);
        chk("rise_after_reset_48", 32'(tb), 32'd48);

        // every word reads zero after the clear
        for (int a = 0; a < 64; a++) begin
            set_p1(1, 0, 4'h0, 6'(a), 32'h0);
            set_p2(1, 0, 4'h0, 6'(63 - a), 32'h0);
            tick();
            chk("cleared_word", rd1_a, 32'h0);
        end
        idle();

        // sequential byte-merged writes at address 5
        set_p1(1, 1, 4'b1111, 6'd5, 32'hDEADBEEF);
        tick();
        idle();
        set_p2(1, 1, 4'b0100, 6'd5, 32'h00AA0000);
        tick();
        idle();
        set_p1(1, 0, 4'h0, 6'd5, 32'h0);
        tick();
        chk("merge_addr5_a", rd1_a, 32'hDEAABEEF);
        chk("merge_addr5_b", rd1_b, 32'hDEAABEEF);

        // same-cycle write collision at address 9
        set_p1(1, 1, 4'b0011, 6'd9, 32'h11111111);
        set_p2(1, 1, 4'b0110, 6'd9, 32'h22222222);
        tick();
        idle();
        set_p1(1, 0, 4'h0, 6'd9, 32'h0);
        tick();
        chk("collision_addr9", rd1_a, 32'h00221111);

        // read-during-write at address 3
        set_p1(1, 1, 4'b1111, 6'd3, 32'hCAFEF00D);
        tick();
        set_p1(1, 0, 4'h0, 6'd3, 32'h0);
        set_p2(1, 1, 4'b0001, 6'd3, 32'h000000FF);
        tick();
        rdw_exp = FWD ? 32'hCAFEF0FF : 32'hCAFEF00D;
        chk("rdw_addr3", rd1_a, rdw_exp);
        idle();
        set_p1(1, 0, 4'h0, 6'd3, 32'h0);
        tick();
        chk("rdw_after_addr3", rd1_a, 32'hCAFEF0FF);

        // clear request with data present; traffic during the sweep is lost
        idle();
        set_p1(1, 1, 4'b1111, 6'd7, 32'h5A5A5A5A);
        tick();
        idle();
        clr = 1;
        tick();
        clr = 0;
        chk("ready_fall_on_clr", {31'd0, rdy_a}, 32'd0);
        ta = 0;
        tb = 0;
        for (int n = 1; n <= 200; n++) begin
            if (n <= 40) begin
                set_p1(1, 1, 4'b1111, 6'd7, 32'hFFFFFFFF);
                set_p2(1, 0, 4'h0, 6'd5, 32'h0);
            end else begin
                idle();
            end
            tick();
            if (n <= 40) chk("rd_during_clear", rd2_a, 32'h0);
            if (rdy_b && tb == 0) tb = n;
            if (rdy_a) begin
                ta = n;
                break;
            end
        end
        idle();
        chk("rise_after_clr_64", 32'(ta), 32'd64);
        chk("rise_after_clr_48", 32'(tb), 32'd48);
        for (int a = 0; a < 64; a++) begin
            set_p1(1, 0, 4'h0, 6'(a), 32'h0);
            tick();
            chk("word_after_clr", rd1_a, 32'h0);
        end
        idle();

        // reset in the middle of a clear sweep
        clr = 1;
        tick();
        clr = 0;
        for (int n = 0; n < 30; n++) tick();
        #2 rst_n = 1'b0;
        model_reset();
        #2;
        check_all();
        #2 rst_n = 1'b1;
        wait_ready(ta, tb);
        chk("rise_after_midclr_rst", 32'(ta), 32'd64);

        // out-of-range access on the 48-deep instance
        set_p1(1, 1, 4'b1111, 6'd2, 32'h12345678);
        tick();
        set_p1(1, 1, 4'b1111, 6'd50, 32'hFFFFFFFF);
        tick();
        set_p1(1, 0, 4'h0, 6'd2, 32'h0);
        set_p2(1, 0, 4'h0, 6'd50, 32'h0);
        tick();
        chk("oor_alias_b", rd1_b, 32'h12345678);
        chk("oor_read_b", rd2_b, 32'h0);
        chk("inrange_50_a", rd2_a, 32'hFFFFFFFF);
        idle();

        // randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            set_p1(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   4'($urandom_range(0, 15)), rnd_addr(), $urandom());
            set_p2(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   4'($urandom_range(0, 15)), rnd_addr(), $urandom());
            clr = ($urandom_range(0, 149) == 0);
            tick();
        end
        idle();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dpram_be_clr.md
# dpram_be_clr

Single-clock true dual-port RAM with per-byte write enables on both ports, parametrised word width and depth, and a hardware clear sequencer that zeroes the array after reset or on request. It replaces the fixed 32-bit, port-2-read-only RAM in the data-memory and peripheral buffer paths. Both ports are full read/write, with a defined collision policy.

## Interface
- DATA_W, 32, word width in bits; multiple of 8, at least 8.
- DEPTH, 64, number of words; at least 2; need not be a power of two.
- ADDR_W, localparam = $clog2(DEPTH), address width.
- BE_W, localparam = DATA_W/8, byte-enable width.

- i_clk  in  1  single clock for both ports and the sequencer.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_clr  in  1  clear request, sampled only in READY.
- o_ready  out  1  high when the array is accessible.
- i_pN_en  in  1  port N access enable (N = 1, 2).
- i_pN_we  in  1  port N write (1) or read (0).
- i_pN_be  in  BE_W  port N byte enables; bit k covers bits [8k+7:8k].
- i_pN_addr  in  ADDR_W  port N word address.
- i_pN_wd  in  DATA_W  port N write data.
- o_pN_rd  out  DATA_W  port N registered read data.

## Operation
- Sequencer FSM states:
  - CLEAR: a counter walks 0..DEPTH-1, writing zero to one word per cycle.
  - READY: normal access.
- Reset drives the FSM to CLEAR with the counter at 0. CLEAR moves to READY after the write to DEPTH-1.
- In READY, i_clr=1 moves the FSM to CLEAR with the counter at 0. Port accesses in that same cycle still execute.
- During CLEAR:
  - All port accesses are ignored; no array writes come from the ports.
  - o_p1_rd and o_p2_rd read as 0.
  - i_clr is ignored.
- Read: en=1, we=0 gives o_pN_rd = RAM[addr] on the next edge.
- Write:
  - en=1, we=1 updates only the bytes whose be bit is 1. be=0 is a no-op.
  - o_pN_rd loads 0 on a write cycle.
- Disabled port: en=0 loads 0 into o_pN_rd on the next edge.
- Out-of-range address (addr >= DEPTH): writes are dropped and reads return 0.
- Write collision (both ports write the same address in one cycle):
  - Port 1 wins on each byte where both be bits are set.
  - Port 2 bytes apply where only port 2 is enabled.
- Read-during-write (one port reads an address the other port writes in the same cycle): behaviour is set by the configuration macro.

## Timing
- Read latency: 1 cycle, addr to o_pN_rd.
- Write latency: the write is visible to a read issued on the following cycle.
- Clear time:
  - After reset release, the first READY cycle is edge DEPTH; o_ready rises then.
  - After i_clr in READY, o_ready falls on the next edge and returns high DEPTH cycles later.
- Reset values: o_ready=0, o_p1_rd=0, o_p2_rd=0, FSM=CLEAR, counter=0. Array contents are undefined until the clear completes.
- Reset asserted mid-clear: the sweep restarts from word 0.
- Reset asserted mid-READY: the array is considered invalid and is fully re-cleared.

## Configuration
- DPRAM_BE_CLR_RDW_FWD_EN
  - Defined (write-first forwarding): a read colliding with the other port's write returns the post-write word. That is the old word merged with the written bytes, after collision resolution.
  - Undefined (read-first): such a read returns the pre-write word.
  - The array contents after the cycle are identical in both modes.

## Test plan
- Reset release, DEPTH=64:
  - o_ready must be low for 64 cycles, then high.
  - Reading every address must return 0x00000000.
- Port 1 writes 0xDEADBEEF with be=4'b1111 at address 5; port 2 then writes 0x00AA0000 with be=4'b0100 at address 5; port 1 reads address 5 one cycle later -> 0xDEAABEEF.
- Same-cycle collision at address 9:
  - Stimulus: p1 wd=0x11111111, be=4'b0011; p2 wd=0x22222222, be=4'b0110.
  - Required: a read the next cycle returns 0x00221111 (from a cleared word).
- Read-during-write at address 3 (old value 0xCAFEF00D):
  - Stimulus: p2 writes 0x000000FF with be=4'b0001 while p1 reads address 3.
  - Required with macro: o_p1_rd = 0xCAFEF0FF. Required without macro: 0xCAFEF00D.
  - Both modes: the following read returns 0xCAFEF0FF.
- i_clr pulse in READY with data present:
  - Port reads during the clear return 0 and writes during the clear are lost.
  - o_ready is low for 64 cycles; afterwards all words read 0.
- Reset asserted at clear cycle 30: the clear restarts and o_ready rises 64 cycles after the release.
- DEPTH=48: a read of address 50 returns 0. A write to address 50 leaves addresses 50-48=2 and 50 mod 48 unchanged.
